// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO access.
// Optional EX_MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier is zero.
module ex_muldiv #(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    // start is a one-cycle request honoured only while busy is low; there is no
    // ready/queueing, so a start seen while busy is dropped.
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [B-1:0] r_data1_in,
    input  logic [B-1:0] r_data2_in,
    input  logic         mthi_we,
    input  logic         mtlo_we,
    input  logic [B-1:0] mt_data,
    output logic [B-1:0] hi_out,
    output logic [B-1:0] lo_out,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(B) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t          state, state_next;
    logic [1:0]      op_q;
    logic            sign_diff_q, rs_neg_q;
    logic [B-1:0]    rs_raw;
    logic [CW-1:0]   cnt;
    logic [2*B-1:0]  mcand, prod;
    logic [B-1:0]    mplier, dsr, quo;
    logic [B:0]      rem;

    logic            signed_op, mul_last, div_last;
    logic [B-1:0]    a_mag, b_mag;
    logic [2*B-1:0]  prod_sum, prod_fix;
    logic [B:0]      shifted;
    logic [B+1:0]    diff;

    assign dbg_state = state;

    always_comb begin
        signed_op = ~op[0];
        a_mag     = (signed_op && r_data1_in[B-1]) ? -r_data1_in : r_data1_in;
        b_mag     = (signed_op && r_data2_in[B-1]) ? -r_data2_in : r_data2_in;
        prod_sum  = prod + (mplier[0] ? mcand : '0);
        prod_fix  = (op_q == 2'b00 && sign_diff_q) ? -prod : prod;
        shifted   = {rem[B-1:0], quo[B-1]};
        // Extra top bit of diff is the borrow: set means the trial subtract failed.
        diff      = {1'b0, shifted} - {2'b00, dsr};
        div_last  = (cnt == CW'(B - 1));
`ifdef EX_MULDIV_EARLY_OUT_EN
        mul_last  = (cnt == CW'(B - 1)) || (mplier[B-1:1] == '0);
`else
        mul_last  = (cnt == CW'(B - 1));
`endif
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = op[1] ? S_DIV : S_MUL;
            S_MUL:   if (mul_last) state_next = S_FIX;
            S_DIV:   if (div_last) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            op_q        <= '0;
            sign_diff_q <= 1'b0;
            rs_neg_q    <= 1'b0;
            rs_raw      <= '0;
            cnt         <= '0;
            mcand       <= '0;
            prod        <= '0;
            mplier      <= '0;
            dsr         <= '0;
            quo         <= '0;
            rem         <= '0;
        end else begin
            state       <= state_next;
            busy        <= (state_next != S_IDLE);
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mthi_we) hi_out <= mt_data;
                    if (mtlo_we) lo_out <= mt_data;
                    if (start) begin
                        op_q        <= op;
                        sign_diff_q <= signed_op & (r_data1_in[B-1] ^ r_data2_in[B-1]);
                        rs_neg_q    <= signed_op & r_data1_in[B-1];
                        rs_raw      <= r_data1_in;
                        cnt         <= '0;
                        prod        <= '0;
                        mcand       <= {{B{1'b0}}, a_mag};
                        mplier      <= b_mag;
                        dsr         <= b_mag;
                        rem         <= '0;
                        quo         <= a_mag;
                    end
                end
                S_MUL: begin
                    prod   <= prod_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                S_DIV: begin
                    if (diff[B+1]) begin
                        rem <= shifted;
                        quo <= {quo[B-2:0], 1'b0};
                    end else begin
                        rem <= diff[B:0];
                        quo <= {quo[B-2:0], 1'b1};
                    end
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (!op_q[1]) begin
                        hi_out <= prod_fix[2*B-1:B];
                        lo_out <= prod_fix[B-1:0];
                    end else if (dsr == '0) begin
                        hi_out      <= rs_raw;
                        lo_out      <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo_out <= (!op_q[0] && sign_diff_q) ? -quo : quo;
                        hi_out <= (!op_q[0] && rs_neg_q) ? -rem[B-1:0] : rem[B-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, fed by the ID/EX pipeline register (rs/rt operand data plus a decoded mul/div start). It computes signed and unsigned products and quotients into architectural HI/LO registers over multiple cycles. It raises `busy` so the hazard unit can freeze PC, IF/ID and ID/EX while it works. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

## Interface
- `B`, 32, operand/result width; iteration count equals `B`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle request from EX decode of the ID/EX opcode/ALUOp; sampled only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `r_data1_in` in B: rs (multiplicand / dividend).
- `r_data2_in` in B: rt (multiplier / divisor).
- `mthi_we` in 1: write `mt_data` to HI; IDLE only.
- `mtlo_we` in 1: write `mt_data` to LO; IDLE only.
- `mt_data` in B: MTHI/MTLO data.
- `hi_out` out B: HI register.
- `lo_out` out B: LO register.
- `busy` out 1: registered, high whenever state ≠ IDLE; drives the stall request.
- `done` out 1: one-cycle pulse when HI/LO are updated by an op.
- `div_by_zero` out 1: one-cycle pulse coincident with `done` for DIV/DIVU with rt = 0.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start`:
  - Latch `op` and sign flags.
  - For signed ops, latch |rs| and |rt| as unsigned B-bit values (|−2^(B−1)| = 2^(B−1)).
  - Clear iteration counter; go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: shift-add, one multiplier bit per cycle into a 2B-bit accumulator. After `B` iterations, go to FIX.
- DIV: restoring division with a (B+1)-bit partial remainder, one quotient bit per cycle. After `B` iterations, go to FIX.
- FIX (one cycle): apply signs, write HI/LO, pulse `done`, return to IDLE.
  - Signed MULT: negate the 2B product when operand signs differ. HI = upper B bits, LO = lower B bits.
  - DIV/DIVU: LO = quotient, HI = remainder. Quotient is negated when signs differ; remainder takes the dividend's sign.
  - Divisor 0: LO = all ones, HI = original rs (unsigned view); `div_by_zero` pulses.
  - Overflow 0x80000000 / −1: LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm with no special case.
- `start` while busy is ignored; no queueing.
- `mthi_we`/`mtlo_we` while busy are ignored. Both together in IDLE write both registers.
- `start` and `mt*_we` together in IDLE: the MT write takes effect, then the op later overwrites HI/LO in FIX.
- Reset, including mid-operation: state IDLE; HI, LO, counter and accumulators 0; `busy`, `done`, `div_by_zero` 0.

## Timing
- Edge E0 samples `start`; `busy` is high from E0 until E(B+1).
- Iteration edges are E1..EB.
- Edge E(B+1) performs FIX. In the following cycle `busy`=0, `done`=1, and new HI/LO are visible.
- Start-to-done latency is B+1 edges (33 for B=32), fixed for all ops without the option below.
- `hi_out`/`lo_out` are direct register outputs and hold their value during an operation, so a stalled MFHI sees the pre-op value until `done`.
- A new `start` is accepted in the same cycle `done` is high, since the state is IDLE.

## Configuration
- `EX_MULDIV_EARLY_OUT_EN` defined: MUL leaves for FIX once the remaining shifted multiplier magnitude is zero. It always runs at least 1 iteration, so latency = (index of highest set bit of |rt|) + 2 edges; rt = 0 takes 2 edges. DIV is unaffected.
- `EX_MULDIV_EARLY_OUT_EN` undefined: MUL always runs `B` iterations, giving fixed latency B+1.

## Test plan
- MULT rs=7, rt=0xFFFFFFFD: HI=0xFFFFFFFF, LO=0xFFFFFFEB; `done` exactly 33 edges after E0 (option off); `busy` high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. With option on, latency is still 33 (top bit set).
- DIV −7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU 0x1234 / 0: LO=0xFFFFFFFF, HI=0x00001234; `div_by_zero` and `done` pulse together.
- MTHI 0xAAAA0000 in IDLE, then MULT 3×4 with a second `start` and `mtlo_we` issued mid-op:
  - `hi_out` stays 0xAAAA0000 until `done`.
  - Final HI=0, LO=12.
  - The mid-op `start` and `mtlo_we` are ignored.
- Reset asserted asynchronously at iteration 10 of a DIV: `busy`, HI and LO are 0 immediately; no `done`; a new `start` after reset runs normally.
